// File: rtl/signed_sat_accumulator_if.sv
// Sample-in / frame-sum-out stream bundle for signed_sat_accumulator.
// Combinational wiring only; no latency of its own.
// Valid/ready on both sides: in_valid/in_ready for samples, out_valid/out_ready for results.
//
// Signals:
//   in_valid  / in_ready  / in_data   - sample stream (master -> accumulator)
//   out_valid / out_ready / out_data  - frame sum stream (accumulator -> master)
//   out_sat                           - frame clamped at least once (SAT_ACC_FLAG_EN only)
// Modports: master = the side feeding samples and taking results; slave = the accumulator.
interface signed_sat_accumulator_if #(
  parameter int W = 4
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_data;
`ifdef SAT_ACC_FLAG_EN
  logic                out_sat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
`endif
endinterface

// File: rtl/signed_sat_accumulator.sv
// Sums frames of N signed W-bit samples with per-step saturation; one result per frame.
// Latency: out_valid rises the cycle after the Nth sample is accepted.
// Backpressure: while a result waits for out_ready, in_ready is low and samples are not taken.
//
// Ports:
//   clk  - single clock, all state on posedge
//   rst  - synchronous active-high reset; discards any partial or pending sum
//   bus  - signed_sat_accumulator_if.slave (sample in, frame sum out)
// Optional feature: define SAT_ACC_FLAG_EN to add bus.out_sat, set when any
// addition in the emitted frame clamped.
module signed_sat_accumulator #(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  signed_sat_accumulator_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]       LAST    = CW'(N - 1);
  localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  state_t              state_q;
  logic signed [W-1:0] acc_q;
  logic [CW-1:0]       cnt_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic signed [W-1:0] out_data_q;

  logic [W:0]          sum_ext;
  logic                sum_clamp;
  logic signed [W-1:0] sum_sat;

  // One extra bit of headroom: the sum overflowed the W-bit range exactly
  // when the top two bits disagree, and the top bit then gives the direction.
  always_comb begin
    sum_ext   = {acc_q[W-1], acc_q} + {bus.in_data[W-1], bus.in_data};
    sum_clamp = sum_ext[W] ^ sum_ext[W-1];
    sum_sat   = sum_ext[W-1:0];
    if (sum_clamp) begin
      sum_sat = sum_ext[W] ? SAT_MIN : SAT_MAX;
    end
  end

`ifdef SAT_ACC_FLAG_EN
  logic flag_q;
  logic out_sat_q;

  // Sticky per-frame clamp flag; the last sample's own clamp is folded in
  // when the result is latched.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q    <= 1'b0;
      out_sat_q <= 1'b0;
    end else if (state_q == ST_ACC) begin
      if (bus.in_valid) begin
        flag_q <= flag_q | sum_clamp;
        if (cnt_q == LAST) begin
          out_sat_q <= flag_q | sum_clamp;
        end
      end
    end else if (bus.out_ready) begin
      flag_q    <= 1'b0;
      out_sat_q <= 1'b0;
    end
  end

  assign bus.out_sat = out_sat_q;
`endif

  // in_ready/out_valid are registered alongside the state, so out_ready
  // never reaches in_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (bus.in_valid) begin
            acc_q <= sum_sat;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              out_data_q  <= sum_sat;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
              state_q     <= ST_OUT;
            end
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_ACC;
          end
        end
        default: begin
          state_q     <= ST_ACC;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// Bench for signed_sat_accumulator (W=4, N=4): directed frames, scoreboard monitor.
// Inputs change 1 time unit after posedge; the monitor samples on negedge.
// Expected sums and clamp flags below are worked out by hand.
module tb_signed_sat_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  signed_sat_accumulator_if #(.W(4)) intf();

  signed_sat_accumulator #(.W(4), .N(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf.slave)
  );

  typedef struct {
    int d;
    int sat;
    int rise_cyc;
  } exp_t;

  exp_t q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called just after the accept edge of a frame's last sample.
  task automatic expect_out(input int d, input int sat);
    exp_t e;
    e.d        = d;
    e.sat      = sat;
    e.rise_cyc = cyc;
    q.push_back(e);
  endtask

  task automatic send(input int d);
    int waits;
    waits = 0;
    intf.in_valid = 1'b1;
    intf.in_data  = 4'(d);
    while (!intf.in_ready && waits < 50) begin
      @(posedge clk);
      #1;
      waits++;
    end
    if (!intf.in_ready) begin
      check("send_timeout", 0, 1);
      intf.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      intf.in_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame(input int s0, input int s1, input int s2, input int s3,
                       input int d, input int sat);
    send(s0);
    send(s1);
    send(s2);
    send(s3);
    expect_out(d, sat);
  endtask

  // Monitor: pops one expectation per rising out_valid, then holds it for
  // the stability check until the result leaves.
  exp_t cur;
  bit   have_cur   = 1'b0;
  bit   prev_valid = 1'b0;

  always @(negedge clk) begin
    if (!rst && intf.out_valid) begin
      if (!prev_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got data %0d, expected no output (cycle %0d)",
                   $signed(intf.out_data), cyc);
          have_cur = 1'b0;
        end else begin
          cur      = q.pop_front();
          have_cur = 1'b1;
          check("rise_cycle", cyc, cur.rise_cyc);
          check("out_data", int'($signed(intf.out_data)), cur.d);
`ifdef SAT_ACC_FLAG_EN
          check("out_sat", int'(intf.out_sat), cur.sat);
`endif
        end
      end else if (have_cur) begin
        check("held_data", int'($signed(intf.out_data)), cur.d);
`ifdef SAT_ACC_FLAG_EN
        check("held_sat", int'(intf.out_sat), cur.sat);
`endif
      end
    end
    prev_valid = !rst && intf.out_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    intf.in_valid  = 1'b0;
    intf.in_data   = '0;
    intf.out_ready = 1'b1;
    rst            = 1'b1;
    idle(2);
    check("rst_out_valid", int'(intf.out_valid), 0);
    check("rst_in_ready", int'(intf.in_ready), 1);
    check("rst_out_data", int'($signed(intf.out_data)), 0);
    rst = 1'b0;

    // Plain sum, no clamp.
    frame(1, 2, -1, 3, 5, 0);
    // 4+7 clamps to 7, then 4, then 5.
    frame(4, 7, -3, 1, 5, 1);
    // -4-7 clamps to -8, -8-8 stays -8, then -6.
    frame(-4, -7, -8, 2, -6, 1);
    // Flag must be cleared by the previous handoff.
    frame(0, 1, 0, 1, 2, 0);
    // Reaching the negative limit exactly is not a clamp.
    frame(-8, 0, 0, 0, -8, 0);

    // Held result under backpressure; samples offered meanwhile are ignored.
    send(7);
    intf.out_ready = 1'b0;
    send(7);
    send(7);
    send(7);
    expect_out(7, 1);
    repeat (5) begin
      intf.in_valid = 1'b1;
      intf.in_data  = 4'sd1;
      check("stall_in_ready", int'(intf.in_ready), 0);
      check("stall_out_valid", int'(intf.out_valid), 1);
      check("stall_out_data", int'($signed(intf.out_data)), 7);
      idle(1);
    end
    intf.in_valid  = 1'b0;
    intf.out_ready = 1'b1;
    idle(1);
    check("handoff_out_valid", int'(intf.out_valid), 0);
    check("handoff_in_ready", int'(intf.in_ready), 1);

    // Reset mid-frame: partial 3+3 is dropped.
    send(3);
    send(3);
    rst = 1'b1;
    idle(1);
    check("midrst_out_valid", int'(intf.out_valid), 0);
    check("midrst_in_ready", int'(intf.in_ready), 1);
    rst = 1'b0;
    frame(1, 1, 1, 1, 4, 0);

    // Bubbles between samples: 2,_,_,2,_,2,2 -> 8 clamps to 7.
    send(2);
    idle(2);
    send(2);
    idle(1);
    send(2);
    send(2);
    expect_out(7, 1);

    idle(6);
    check("pending_results", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
